// File: rtl/mm_pass_sequencer.sv
// mm_pass_sequencer: walks one full A x s multiply pass, fetching packed words from BRAM and
// offering them to the multiplier row by row. Optional stall counter: MM_SEQ_STALL_CNT_EN.
module mm_pass_sequencer #(
    parameter int DEPTH  = 784,
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 10,
    parameter int CNT_W  = 18
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             abort_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [IDX_W-1:0] a_addr_out,
    input  logic [35:0]      a_rdata_in,
    output logic [IDX_W-1:0] s_addr_out,
    input  logic [1:0]       s_rdata_in,
    output logic             A_valid_out,
    output logic [IDX_W-1:0] A_idx_out,
    output logic [35:0]      pk_A_out,
    input  logic             A_ready_in,
    output logic             s_valid_out,
    output logic [IDX_W-1:0] s_idx_out,
    output logic [1:0]       sk_s_out,
    input  logic             s_ready_in,
    input  logic             B_valid_in,
    output logic [CNT_W-1:0] prod_cnt_out
`ifdef MM_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt_out
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        OFFER_A,
        FETCH_S,
        OFFER_S,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'((DEPTH / 2) * (DEPTH / 2));
    localparam logic [1:0]       LAT_END  = 2'(RD_LAT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] a_i_q, a_i_d;
    logic [IDX_W-1:0] s_i_q, s_i_d;
    logic [1:0]       wait_q, wait_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_valid_q, a_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [IDX_W-1:0] a_idx_q, a_idx_d;
    logic [IDX_W-1:0] s_idx_q, s_idx_d;
    logic [35:0]      pk_a_q, pk_a_d;
    logic [1:0]       sk_s_q, sk_s_d;
    logic [CNT_W-1:0] prod_cnt_q, prod_cnt_d;
    logic             in_pass;
    logic             aborting;
`ifdef MM_SEQ_STALL_CNT_EN
    logic [31:0]      stall_q, stall_d;
`endif

    // Products and stalls are only counted between an accepted start and the DONE state.
    assign in_pass  = (state_q != IDLE) && (state_q != DONE);
    assign aborting = abort_in && (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        a_i_d      = a_i_q;
        s_i_d      = s_i_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        a_valid_d  = a_valid_q;
        s_valid_d  = s_valid_q;
        a_idx_d    = a_idx_q;
        s_idx_d    = s_idx_q;
        pk_a_d     = pk_a_q;
        sk_s_d     = sk_s_q;
        prod_cnt_d = prod_cnt_q;

        if (aborting) begin
            state_d   = IDLE;
            a_valid_d = 1'b0;
            s_valid_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            if (in_pass && B_valid_in) begin
                prod_cnt_d = prod_cnt_q + CNT_W'(1);
            end
            // A fetch spends one cycle presenting the registered address, then RD_LAT read cycles.
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        a_i_d      = '0;
                        s_i_d      = '0;
                        prod_cnt_d = '0;
                        wait_d     = '0;
                        busy_d     = 1'b1;
                        state_d    = FETCH_A;
                    end
                end
                FETCH_A: begin
                    if (wait_q == LAT_END) begin
                        pk_a_d    = a_rdata_in;
                        a_idx_d   = a_i_q;
                        a_valid_d = 1'b1;
                        state_d   = OFFER_A;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                OFFER_A: begin
                    if (A_ready_in) begin
                        a_valid_d = 1'b0;
                        wait_d    = '0;
                        state_d   = FETCH_S;
                    end
                end
                FETCH_S: begin
                    if (wait_q == LAT_END) begin
                        sk_s_d    = s_rdata_in;
                        s_idx_d   = s_i_q;
                        s_valid_d = 1'b1;
                        state_d   = OFFER_S;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                OFFER_S: begin
                    if (s_ready_in) begin
                        s_valid_d = 1'b0;
                        wait_d    = '0;
                        if (s_i_q != LAST_IDX) begin
                            s_i_d   = s_i_q + IDX_W'(2);
                            state_d = FETCH_S;
                        end else if (a_i_q != LAST_IDX) begin
                            s_i_d   = '0;
                            a_i_d   = a_i_q + IDX_W'(2);
                            state_d = FETCH_A;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (prod_cnt_q == TOTAL) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef MM_SEQ_STALL_CNT_EN
    always_comb begin
        stall_d = stall_q;
        if (!aborting) begin
            if (state_q == IDLE && start_in) begin
                stall_d = '0;
            end else if (in_pass && ((a_valid_q && !A_ready_in) || (s_valid_q && !s_ready_in))) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_out = stall_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            a_i_q      <= '0;
            s_i_q      <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            a_idx_q    <= '0;
            s_idx_q    <= '0;
            pk_a_q     <= '0;
            sk_s_q     <= '0;
            prod_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_i_q      <= a_i_d;
            s_i_q      <= s_i_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_valid_q  <= a_valid_d;
            s_valid_q  <= s_valid_d;
            a_idx_q    <= a_idx_d;
            s_idx_q    <= s_idx_d;
            pk_a_q     <= pk_a_d;
            sk_s_q     <= sk_s_d;
            prod_cnt_q <= prod_cnt_d;
        end
    end

    assign a_addr_out   = {1'b0, a_i_q[IDX_W-1:1]};
    assign s_addr_out   = {1'b0, s_i_q[IDX_W-1:1]};
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign A_valid_out  = a_valid_q;
    assign A_idx_out    = a_idx_q;
    assign pk_A_out     = pk_a_q;
    assign s_valid_out  = s_valid_q;
    assign s_idx_out    = s_idx_q;
    assign sk_s_out     = sk_s_q;
    assign prod_cnt_out = prod_cnt_q;

endmodule

// File: tb/tb_mm_pass_sequencer.sv
// Bench for mm_pass_sequencer: three instances (read latency 2, 1, 3) share stimulus and are
// checked every cycle against a transfer-sequence model; stall checks need MM_SEQ_STALL_CNT_EN.
module tb_mm_pass_sequencer;

    localparam int NDUT  = 3;
    localparam int DEPTH = 8;
    localparam int D2    = DEPTH / 2;
    localparam int NT    = D2 * (D2 + 1);
    localparam int TOTAL = D2 * D2;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk = 1'b0;
    logic rst, start, abort, aReady, sReady, bExtra;
    logic randMode = 1'b0;

    wire  [NDUT-1:0] aValid, sValid, busy, done;
    wire  [9:0]      aAddr [NDUT];
    wire  [9:0]      sAddr [NDUT];
    wire  [9:0]      aIdx  [NDUT];
    wire  [9:0]      sIdx  [NDUT];
    wire  [35:0]     pkA   [NDUT];
    wire  [1:0]      skS   [NDUT];
    wire  [17:0]     prodCnt [NDUT];
`ifdef MM_SEQ_STALL_CNT_EN
    wire  [31:0]     stallCnt [NDUT];
`endif

    logic [NDUT-1:0] bEcho;
    logic [35:0]     aPipe [NDUT][3];
    logic [1:0]      sPipe [NDUT][3];
    logic [35:0]     memA [D2];
    logic [1:0]      memS [D2];

    int checks = 0;
    int errors = 0;

    int          mPhase [NDUT];
    int          mPos [NDUT];
    int          mCnt [NDUT];
    int          mStall [NDUT];
    int          xferCnt [NDUT];
    int          doneSeen [NDUT];
    logic        holdA [NDUT];
    logic        holdS [NDUT];
    logic [35:0] holdPk [NDUT];
    logic [1:0]  holdSk [NDUT];
    logic [9:0]  holdAi [NDUT];
    logic [9:0]  holdSi [NDUT];
    logic [35:0] lastA [NDUT];
    logic [1:0]  lastS [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        mm_pass_sequencer #(
            .DEPTH(DEPTH),
            .RD_LAT(LAT),
            .IDX_W(10),
            .CNT_W(18)
        ) dut (
            .clk_in(clk),
            .rst_in(rst),
            .start_in(start),
            .abort_in(abort),
            .busy_out(busy[g]),
            .done_out(done[g]),
            .a_addr_out(aAddr[g]),
            .a_rdata_in(aPipe[g][LAT-1]),
            .s_addr_out(sAddr[g]),
            .s_rdata_in(sPipe[g][LAT-1]),
            .A_valid_out(aValid[g]),
            .A_idx_out(aIdx[g]),
            .pk_A_out(pkA[g]),
            .A_ready_in(aReady),
            .s_valid_out(sValid[g]),
            .s_idx_out(sIdx[g]),
            .sk_s_out(skS[g]),
            .s_ready_in(sReady),
            .B_valid_in(bEcho[g] | bExtra),
            .prod_cnt_out(prodCnt[g])
`ifdef MM_SEQ_STALL_CNT_EN
            ,
            .stall_cnt_out(stallCnt[g])
`endif
        );
    end

    // BRAM read pipelines and a multiplier stand-in that returns one product per s transfer.
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            aPipe[g][0] <= memA[aAddr[g][1:0]];
            aPipe[g][1] <= aPipe[g][0];
            aPipe[g][2] <= aPipe[g][1];
            sPipe[g][0] <= memS[sAddr[g][1:0]];
            sPipe[g][1] <= sPipe[g][0];
            sPipe[g][2] <= sPipe[g][1];
            bEcho[g]    <= rst ? 1'b0 : (sValid[g] && sReady);
        end
    end

    task automatic reportFail(input string name, input int g, input logic [63:0] act,
                              input logic [63:0] exp);
        errors++;
        $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, g, act, exp);
    endtask

    task automatic checkOutput(input string name, input int g, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) reportFail(name, g, act, exp);
    endtask

    // Row-major order: entry k of a pass is the A word of row k/(D2+1) or one of its s words.
    task automatic checkXfer(input int g, input bit isA, input logic [9:0] idx,
                             input logic [35:0] pay);
        int k, r, c, expIdx;
        bit expIsA;
        k = mPos[g];
        if (k >= NT) begin
            checks++;
            reportFail("xferExtra", g, 64'(k), 64'(NT - 1));
        end else begin
            r      = k / (D2 + 1);
            c      = k % (D2 + 1);
            expIsA = (c == 0);
            expIdx = expIsA ? 2 * r : 2 * (c - 1);
            checkOutput("xferChan", g, 64'(isA), 64'(expIsA));
            checkOutput("xferIdx", g, 64'(idx), 64'(expIdx));
            if (expIsA) checkOutput("xferDataA", g, 64'(pay), 64'(memA[expIdx / 2]));
            else        checkOutput("xferDataS", g, 64'(pay), 64'(memS[expIdx / 2]));
        end
        if (isA) lastA[g] = pay;
        else     lastS[g] = pay[1:0];
        mPos[g]++;
        xferCnt[g]++;
    endtask

    // Compare outputs against the model, then advance the model over the upcoming edge.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (!rst) begin
                checkOutput("busy", g, 64'(busy[g]), 64'(mPhase[g] == PH_RUN));
                checkOutput("done", g, 64'(done[g]), 64'(mPhase[g] == PH_DONE));
                checkOutput("prodCnt", g, 64'(prodCnt[g]), 64'(mCnt[g]));
                if (mPhase[g] != PH_RUN) begin
                    checkOutput("aValidOff", g, 64'(aValid[g]), 64'd0);
                    checkOutput("sValidOff", g, 64'(sValid[g]), 64'd0);
                end
`ifdef MM_SEQ_STALL_CNT_EN
                checkOutput("stallCnt", g, 64'(stallCnt[g]), 64'(mStall[g]));
`endif
                if (holdA[g]) begin
                    checkOutput("aHoldValid", g, 64'(aValid[g]), 64'd1);
                    checkOutput("aHoldData", g, 64'(pkA[g]), 64'(holdPk[g]));
                    checkOutput("aHoldIdx", g, 64'(aIdx[g]), 64'(holdAi[g]));
                end
                if (holdS[g]) begin
                    checkOutput("sHoldValid", g, 64'(sValid[g]), 64'd1);
                    checkOutput("sHoldData", g, 64'(skS[g]), 64'(holdSk[g]));
                    checkOutput("sHoldIdx", g, 64'(sIdx[g]), 64'(holdSi[g]));
                end
                if (done[g]) doneSeen[g]++;
            end
            holdA[g] = 1'b0;
            holdS[g] = 1'b0;
            if (rst) begin
                mPhase[g] = PH_IDLE;
                mPos[g]   = 0;
                mCnt[g]   = 0;
                mStall[g] = 0;
            end else begin
                case (mPhase[g])
                    PH_IDLE: begin
                        if (start && !abort) begin
                            mPhase[g]   = PH_RUN;
                            mPos[g]     = 0;
                            mCnt[g]     = 0;
                            mStall[g]   = 0;
                            xferCnt[g]  = 0;
                            doneSeen[g] = 0;
                        end
                    end
                    PH_RUN: begin
                        if (abort) begin
                            mPhase[g] = PH_IDLE;
                        end else begin
                            if ((aValid[g] && !aReady) || (sValid[g] && !sReady)) mStall[g]++;
                            if (mPos[g] == NT && mCnt[g] == TOTAL) mPhase[g] = PH_DONE;
                            if (bEcho[g] | bExtra) mCnt[g]++;
                            if (aValid[g] && aReady) checkXfer(g, 1'b1, aIdx[g], pkA[g]);
                            if (sValid[g] && sReady) checkXfer(g, 1'b0, sIdx[g], 36'(skS[g]));
                            holdA[g]  = aValid[g] && !aReady;
                            holdS[g]  = sValid[g] && !sReady;
                            holdPk[g] = pkA[g];
                            holdAi[g] = aIdx[g];
                            holdSk[g] = skS[g];
                            holdSi[g] = sIdx[g];
                        end
                    end
                    default: mPhase[g] = PH_IDLE;
                endcase
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic ab);
        @(posedge clk);
        #1;
        start = st;
        abort = ab;
        if (randMode) begin
            aReady = 1'($urandom_range(0, 1));
            sReady = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic waitAllIdle(input string name);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            applyStimulus(1'b0, 1'b0);
            idle = 1'b1;
            for (int g = 0; g < NDUT; g++) if (mPhase[g] != PH_IDLE) idle = 1'b0;
        end
        if (!idle) begin
            checks++;
            reportFail(name, 0, 64'd0, 64'd1);
        end
    endtask

    task automatic checkFullPass(input string name);
        for (int g = 0; g < NDUT; g++) begin
            checkOutput({name, "_prod"}, g, 64'(prodCnt[g]), 64'd16);
            checkOutput({name, "_xfers"}, g, 64'(xferCnt[g]), 64'd20);
            checkOutput({name, "_doneCnt"}, g, 64'(doneSeen[g]), 64'd1);
            checkOutput({name, "_lastA"}, g, 64'(lastA[g]), 64'h000200003);
            checkOutput({name, "_lastS"}, g, 64'(lastS[g]), 64'd3);
            checkOutput({name, "_busy"}, g, 64'(busy[g]), 64'd0);
        end
    endtask

    initial begin
        bit found;
        for (int k = 0; k < D2; k++) begin
            memA[k] = {18'(k + 5), 18'(k)};
            memS[k] = 2'(k);
        end
        for (int g = 0; g < NDUT; g++) begin
            mPhase[g] = PH_IDLE; mPos[g] = 0; mCnt[g] = 0; mStall[g] = 0;
            xferCnt[g] = 0; doneSeen[g] = 0; holdA[g] = 1'b0; holdS[g] = 1'b0;
            lastA[g] = '0; lastS[g] = '0;
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; aReady = 1'b1; sReady = 1'b1; bExtra = 1'b0;

        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("rstAValid", 0, 64'(aValid[0]), 64'd0);
        checkOutput("rstSValid", 0, 64'(sValid[0]), 64'd0);
        checkOutput("rstBusy", 0, 64'(busy[0]), 64'd0);
        checkOutput("rstDone", 0, 64'(done[0]), 64'd0);
        checkOutput("rstProd", 0, 64'(prodCnt[0]), 64'd0);
        checkOutput("rstAAddr", 0, 64'(aAddr[0]), 64'd0);
        checkOutput("rstSAddr", 0, 64'(sAddr[0]), 64'd0);
        checkOutput("rstAIdx", 0, 64'(aIdx[0]), 64'd0);
        checkOutput("rstSIdx", 0, 64'(sIdx[0]), 64'd0);
        checkOutput("rstPkA", 0, 64'(pkA[0]), 64'd0);
        checkOutput("rstSkS", 0, 64'(skS[0]), 64'd0);
        rst = 1'b0;

        $display("[TB] pass with ready held high");
        applyStimulus(1'b1, 1'b0);
        waitAllIdle("pass1Timeout");
        checkFullPass("pass1");

        $display("[TB] pass with random ready");
        randMode = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitAllIdle("pass2Timeout");
        randMode = 1'b0;
        aReady = 1'b1;
        sReady = 1'b1;
        checkFullPass("pass2");

        $display("[TB] abort during second s offer of row 1");
        applyStimulus(1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            applyStimulus(1'b0, 1'b0);
            if (sValid[0] && sIdx[0] == 10'd2 && aIdx[0] == 10'd2) begin
                sReady = 1'b0;
                found  = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            reportFail("abortSearch", 0, 64'd0, 64'd1);
        end
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        sReady = 1'b1;
        checkOutput("abortSValid", 0, 64'(sValid[0]), 64'd0);
        checkOutput("abortBusy", 0, 64'(busy[0]), 64'd0);
        checkOutput("abortDoneCnt", 0, 64'(doneSeen[0]), 64'd0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitAllIdle("pass3Timeout");
        checkFullPass("pass3");

        $display("[TB] B strobes in IDLE and start pulsed mid-pass");
        bExtra = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0);
        bExtra = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idleBProd", 0, 64'(prodCnt[0]), 64'd16);
        applyStimulus(1'b1, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitAllIdle("pass4Timeout");
        checkFullPass("pass4");

`ifdef MM_SEQ_STALL_CNT_EN
        $display("[TB] five-cycle s stall");
        applyStimulus(1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            applyStimulus(1'b0, 1'b0);
            if (sValid[0]) begin
                sReady = 1'b0;
                found  = 1'b1;
            end
        end
        repeat (4) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        sReady = 1'b1;
        waitAllIdle("pass5Timeout");
        checkOutput("stallFive", 0, 64'(stallCnt[0]), 64'd5);
        checkOutput("stallProd", 0, 64'(prodCnt[0]), 64'd16);
`endif

        repeat (3) applyStimulus(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
